// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch program-counter generator with BOOT/RUN/HALT control,
//            trap/branch redirect and a valid/ready request to instruction memory.
//            Optional macro PC_ALIGN_CHECK_EN enables the misaligned-target pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                IALIGN       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt,
  input  logic            resume,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            halted,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] C_LOW_MASK = XLEN'(IALIGN - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, halted_q, mis_q, mis_d;
  logic              trap_low, br_low;

`ifdef PC_ALIGN_CHECK_EN
  assign trap_low = |(trap_target & C_LOW_MASK);
  assign br_low   = |(br_target & C_LOW_MASK);
`else
  assign trap_low = 1'b0;
  assign br_low   = 1'b0;
`endif

  assign pc_plus = pc_q + XLEN'(IALIGN);

  // Next PC: trap over branch over stall over handshake advance.
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trap) begin
          pc_d  = trap_target & ~C_LOW_MASK;
          mis_d = trap_low;
        end else if (br_taken) begin
          pc_d  = br_target & ~C_LOW_MASK;
          mis_d = br_low;
        end else if (!stall && valid_q && imem_req_ready) begin
          pc_d  = pc_plus;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_d  = trap_target & ~C_LOW_MASK;
          mis_d = trap_low;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
        ST_RUN: begin
          // A redirect in the same cycle wins over halt.
          if (!trap && !br_taken && halt) begin
            state_q  <= ST_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (trap || resume) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_BOOT;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc             = pc_q;
  assign imem_req_valid = valid_q;
  assign halted         = halted_q;
  assign misaligned     = mis_q;

endmodule

`default_nettype wire
